count_capture: RTL and testbench
================================

COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter BITS, default 30: width of the captured count word.
REQ-002 Parameter DEPTH, default 8: number of FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter BASE_ADDR, default 32'h3000_0000: Wishbone base address of the register window.
REQ-004 Port wb_clk_i, input, 1: the single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 Port wb_rst_i, input, 1: reset, asynchronous assert, active-low (0 = reset).
REQ-006 Ports wbs_cyc_i, wbs_stb_i, wbs_we_i, input, 1 each: Wishbone classic cycle, strobe and write-enable.
REQ-007 Port wbs_sel_i, input, 4: byte lanes, ANDed with wbs_we_i for writes.
REQ-008 Ports wbs_adr_i and wbs_dat_i, input, 32 each: address and write data.
REQ-009 Port wbs_ack_o, output, 1: transfer acknowledge.
REQ-010 Port wbs_dat_o, output, 32: read data.
REQ-011 Port count_i, input, BITS: live value from the upstream counter.
REQ-012 Port trig_i, input, 1: capture trigger, typically an LA or IO pin.
REQ-013 Port irq_o, output, 1: level interrupt.

Function
REQ-014 valid = cyc & stb & (adr[31:4] == BASE_ADDR[31:4]); offsets are selected by adr[3:2].
REQ-015 wbs_ack_o SHALL pulse high for exactly one cycle, in the cycle after valid is seen with ack low; there is no back-to-back ack.
REQ-016 Offset 0x0 DATA (read): returns {zero-ext, FIFO head} and pops in the ack cycle. When the FIFO is empty it returns 0 and does not pop. Writes are ignored.
REQ-017 Offset 0x4 STATUS (read-only): [3:0] level, [4] empty, [5] full, [6] overflow (sticky), [7] irq_o.
REQ-018 Offset 0x8 CTRL (read/write): [0] enable, [4:1] threshold, [8] clear.
REQ-019 CTRL[8] SHALL be self-clearing: writing 1 empties the FIFO and clears overflow in the ack cycle, and it always reads 0.
REQ-020 Offset 0xC (reserved): reads return 0, writes are ignored, and the access is still acked.
REQ-021 A byte-lane write updates only the CTRL bits that lie in the enabled lanes.
REQ-022 A capture event is a rising edge of the (optionally synchronised) trigger while enable=1. It pushes count_i as sampled in the same cycle the edge is detected.
REQ-023 A push while full SHALL be dropped and set overflow; FIFO contents are unchanged.
REQ-024 A push and a pop in the same cycle SHALL both occur, leaving level unchanged. When the FIFO is empty, the pushed word is not popped in that cycle.
REQ-025 A push and a clear in the same cycle: clear wins, and the FIFO ends empty.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH. Level SHALL range from 0 to DEPTH inclusive.
REQ-027 irq_o = enable & (threshold != 0) & (level >= threshold), registered with one cycle of latency.

Reset
REQ-028 While wb_rst_i=0, all outputs SHALL be 0: ack=0, dat=0, irq=0.
REQ-029 While wb_rst_i=0: pointers=0, level=0, overflow=0, CTRL=0, and the edge detector history=0.
REQ-030 Reset asserted mid-transfer SHALL abort that transfer with no ack. The first cycle after release behaves as idle.

Configuration
REQ-031 Macro COUNT_CAPTURE_SYNC_EN.
  - When defined: trig_i passes through a 2-flop synchroniser before edge detection, so capture occurs 3 cycles after the input edge.
  - When undefined: trig_i is edge-detected directly, so capture occurs 1 cycle after the input edge.

Structure
REQ-032 The shared package count_capture_pkg SHALL hold:
  - register offset constants (DATA, STATUS, CTRL);
  - CTRL/STATUS bit-position constants;
  - the default DEPTH.
REQ-033 The FIFO SHALL be a sub-module named count_capture_fifo, with ports push, pop, clr, din, dout, level, full, empty.

Verification
REQ-034 Reset, enable=1, count_i=100, one trig edge → DATA read returns 100, and STATUS shows empty=1.
REQ-035 DEPTH+1 trig edges with count_i=1..9 → STATUS full=1, overflow=1; reads return 1..8, then a 9th read returns 0.
REQ-036 Threshold=3, three captures → irq_o rises one cycle after level reaches 3. A single pop → irq_o=0.
REQ-037 Trig edge in the same cycle as a DATA pop with level=2 → level remains 2, and order is preserved.
REQ-038 Write CTRL=0x101 with sel=4'b0011 while FIFO level=5 → FIFO empty, overflow=0, enable=1, CTRL reads 0x001.
REQ-039 Reset pulsed during an outstanding valid → no ack is issued; all STATUS fields read 0, except empty=1.

Source files
------------

// File: rtl/count_capture_pkg.sv
// Shared constants for count_capture: register offsets, CTRL/STATUS bit positions, default depth.
package count_capture_pkg;

   localparam int unsigned DEFAULT_DEPTH = 8;

   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CTRL   = 4'h8;
   localparam logic [3:0] OFF_RSVD   = 4'hC;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_THR_LSB = 1;
   localparam int unsigned CTRL_THR_MSB = 4;
   localparam int unsigned CTRL_CLR_BIT = 8;

   localparam int unsigned STAT_LVL_LSB   = 0;
   localparam int unsigned STAT_LVL_MSB   = 3;
   localparam int unsigned STAT_EMPTY_BIT = 4;
   localparam int unsigned STAT_FULL_BIT  = 5;
   localparam int unsigned STAT_OVF_BIT   = 6;
   localparam int unsigned STAT_IRQ_BIT   = 7;

endpackage

// File: rtl/count_capture_fifo.sv
// Capture FIFO: power-of-two depth, wrapping pointers, level 0..DEPTH, clear wins over push/pop.
module count_capture_fifo #(
   parameter int unsigned BITS  = 30,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clr,
   input  logic [BITS-1:0]            din,
   output logic [BITS-1:0]            dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [BITS-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_pop_c;
   logic            do_push_c;

   assign full      = (level == LW'(DEPTH));
   assign empty     = (level == '0);
   assign do_pop_c  = pop & ~empty;
   // a pop in the same cycle frees the slot a push into a full FIFO needs
   assign do_push_c = push & (~full | do_pop_c);
   assign dout      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push_c && !clr) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(do_push_c) - LW'(do_pop_c);
      end
   end

endmodule

// File: rtl/count_capture.sv
// Wishbone-mapped counter capture: trig_i edges push count_i into a FIFO read back over the bus.
// Define COUNT_CAPTURE_SYNC_EN to pass trig_i through a 2-flop synchroniser before edge detection.
module count_capture
   import count_capture_pkg::*;
#(
   parameter int unsigned BITS      = 30,
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   input  logic [BITS-1:0] count_i,
   input  logic            trig_i,
   output logic            irq_o
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic            armed;
   logic            ctrl_en;
   logic [3:0]      ctrl_thr;
   logic            ovf;
   logic            trig_s;
   logic            trig_d;
   logic [BITS-1:0] head;
   logic [LW-1:0]   level;
   logic            full;
   logic            empty;

   logic            valid_c;
   logic            start_c;
   logic [3:0]      off_c;
   logic            rd_c;
   logic            wr_c;
   logic            pop_c;
   logic            push_c;
   logic            clr_c;
   logic            ctrl_wr_c;
   logic            ovf_set_c;
   logic            irq_next_c;
   logic [31:0]     rdata_c;
   logic            unused_c;

   // armed stays low for the first cycle after reset so a held strobe is not acked then
   assign valid_c   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign start_c   = valid_c & ~wbs_ack_o & armed;
   assign off_c     = {wbs_adr_i[3:2], 2'b00};
   assign rd_c      = start_c & ~wbs_we_i;
   assign wr_c      = start_c & wbs_we_i;
   assign pop_c     = rd_c & (off_c == OFF_DATA) & ~empty;
   assign ctrl_wr_c = wr_c & (off_c == OFF_CTRL) & wbs_sel_i[0];
   assign clr_c     = wr_c & (off_c == OFF_CTRL) & wbs_sel_i[1] & wbs_dat_i[CTRL_CLR_BIT];
   assign push_c    = trig_s & ~trig_d & ctrl_en;
   assign ovf_set_c = push_c & full & ~pop_c;
   assign irq_next_c = ctrl_en & (ctrl_thr != 4'd0) & (32'(level) >= 32'(ctrl_thr));
   assign unused_c  = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:9], wbs_dat_i[7:5], wbs_sel_i[3:2]};

`ifdef COUNT_CAPTURE_SYNC_EN
   logic [1:0] trig_sync;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) trig_sync <= '0;
      else           trig_sync <= {trig_sync[0], trig_i};
   end

   assign trig_s = trig_sync[1];
`else
   assign trig_s = trig_i;
`endif

   // register read mux
   always_comb begin
      rdata_c = '0;
      case (off_c)
         OFF_DATA: begin
            if (!empty) rdata_c = 32'(head);
         end
         OFF_STATUS: begin
            rdata_c[STAT_LVL_MSB:STAT_LVL_LSB] = 4'(level);
            rdata_c[STAT_EMPTY_BIT]            = empty;
            rdata_c[STAT_FULL_BIT]             = full;
            rdata_c[STAT_OVF_BIT]              = ovf;
            rdata_c[STAT_IRQ_BIT]              = irq_o;
         end
         OFF_CTRL: begin
            rdata_c[CTRL_EN_BIT]                = ctrl_en;
            rdata_c[CTRL_THR_MSB:CTRL_THR_LSB] = ctrl_thr;
         end
         default: rdata_c = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         armed     <= 1'b0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         ctrl_en   <= 1'b0;
         ctrl_thr  <= '0;
         ovf       <= 1'b0;
         trig_d    <= 1'b0;
         irq_o     <= 1'b0;
      end else begin
         armed     <= 1'b1;
         wbs_ack_o <= start_c;
         wbs_dat_o <= rd_c ? rdata_c : '0;
         trig_d    <= trig_s;
         irq_o     <= irq_next_c;
         if (ctrl_wr_c) begin
            ctrl_en  <= wbs_dat_i[CTRL_EN_BIT];
            ctrl_thr <= wbs_dat_i[CTRL_THR_MSB:CTRL_THR_LSB];
         end
         if (clr_c)          ovf <= 1'b0;
         else if (ovf_set_c) ovf <= 1'b1;
      end
   end

   count_capture_fifo #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_i),
      .push  (push_c),
      .pop   (pop_c),
      .clr   (clr_c),
      .din   (count_i),
      .dout  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_count_capture.sv
// Scoreboard bench for count_capture: expected bus read data is queued at issue and checked on ack.
`timescale 1ns/1ps
module tb_count_capture;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [3:0]  A_DATA = 4'h0;
   localparam logic [3:0]  A_STAT = 4'h4;
   localparam logic [3:0]  A_CTRL = 4'h8;
   localparam logic [3:0]  A_RSVD = 4'hC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0;
   logic [31:0] wdat = '0;
   logic        ack;
   logic [31:0] dat_o;
   logic [29:0] cnt = '0;
   logic        trig = 1'b0;
   logic        irq;

   string       exp_name_q[$];
   logic [31:0] exp_dat_q[$];
   string       mon_nm;
   logic [31:0] mon_exp;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   count_capture dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst_n),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o),
      .count_i   (cnt),
      .trig_i    (trig),
      .irq_o     (irq)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   // every ack is matched against the oldest queued expectation
   task automatic mon_step();
      if (ack === 1'b1) begin
         if (exp_dat_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack with data 0x%08h, required no ack", dat_o);
         end else begin
            mon_nm  = exp_name_q.pop_front();
            mon_exp = exp_dat_q.pop_front();
            check(mon_nm, dat_o, mon_exp);
         end
      end
   endtask

   task automatic wb_xfer(input string nm, input logic w, input logic [3:0] off,
                          input logic [31:0] wd, input logic [3:0] sl, input logic [31:0] exp);
      int n;
      exp_name_q.push_back(nm);
      exp_dat_q.push_back(exp);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | 32'(off); wdat = wd; sel = sl;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack !== 1'b1 && n < 20);
      if (ack !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got no ack in %0d cycles, required ack", nm, n);
         void'(exp_name_q.pop_back());
         void'(exp_dat_q.pop_back());
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [3:0] off, input logic [31:0] exp);
      wb_xfer(nm, 1'b0, off, 32'h0, 4'hF, exp);
   endtask

   task automatic wr(input string nm, input logic [3:0] off, input logic [31:0] d, input logic [3:0] sl);
      wb_xfer(nm, 1'b1, off, d, sl, 32'h0);
   endtask

   task automatic pulse(input int v);
      @(negedge clk);
      cnt = 30'(v);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1);
   end

   initial begin
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
      join_none

      // reset state, including a strobe held during reset
      repeat (2) @(negedge clk);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_dat", dat_o, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      cyc = 1'b1; stb = 1'b1; adr = BASE | 32'(A_STAT);
      @(negedge clk);
      check("rst_no_ack", 32'(ack), 32'h0);
      cyc = 1'b0; stb = 1'b0;
      rst_n = 1'b1;
      rd("stat_after_rst", A_STAT, 32'h10);
      rd("ctrl_after_rst", A_CTRL, 32'h0);

      // single capture
      wr("wr_enable", A_CTRL, 32'h1, 4'hF);
      pulse(100);
      rd("stat_lvl1", A_STAT, 32'h01);
      rd("data_100", A_DATA, 32'd100);
      rd("stat_empty", A_STAT, 32'h10);

      // overflow: nine edges into eight entries
      for (int i = 1; i <= 9; i++) pulse(i);
      rd("stat_full_ovf", A_STAT, 32'h68);
      for (int i = 1; i <= 8; i++) rd($sformatf("drain_%0d", i), A_DATA, 32'(i));
      rd("data_empty_zero", A_DATA, 32'h0);
      rd("stat_ovf_sticky", A_STAT, 32'h50);
      wr("wr_clear", A_CTRL, 32'h101, 4'hF);
      rd("stat_cleared", A_STAT, 32'h10);
      rd("ctrl_clr_reads0", A_CTRL, 32'h1);

      // threshold interrupt
      wr("wr_thr3", A_CTRL, 32'h7, 4'hF);
      pulse(11);
      pulse(12);
      pulse(13);
      check("irq_latency0", 32'(irq), 32'h0);
      @(negedge clk);
      check("irq_rise", 32'(irq), 32'h1);
      rd("stat_irq", A_STAT, 32'h83);
      rd("data_11", A_DATA, 32'd11);
      @(negedge clk);
      check("irq_fall", 32'(irq), 32'h0);
      rd("stat_lvl2", A_STAT, 32'h02);

      // push and pop in the same cycle at level 2
      exp_name_q.push_back("pp_data_12");
      exp_dat_q.push_back(32'd12);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'(A_DATA);
      cnt = 30'd14; trig = 1'b1;
      @(negedge clk);
      check("pp_ack", 32'(ack), 32'h1);
      cyc = 1'b0; stb = 1'b0; trig = 1'b0;
      rd("pp_stat_lvl2", A_STAT, 32'h02);
      rd("pp_data_13", A_DATA, 32'd13);
      rd("pp_data_14", A_DATA, 32'd14);
      rd("pp_stat_empty", A_STAT, 32'h10);

      // byte-lane CTRL write with clear at level 5, plus ignored writes
      wr("wr_en_thr0", A_CTRL, 32'h1, 4'hF);
      for (int i = 21; i <= 25; i++) pulse(i);
      rd("stat_lvl5", A_STAT, 32'h05);
      wr("wr_data_ignored", A_DATA, 32'h55, 4'hF);
      rd("stat_still5", A_STAT, 32'h05);
      rd("rsvd_read0", A_RSVD, 32'h0);
      wr("rsvd_write", A_RSVD, 32'hFFFF_FFFF, 4'hF);
      wr("wr_101_sel3", A_CTRL, 32'h101, 4'b0011);
      rd("stat_after_lane_clr", A_STAT, 32'h10);
      rd("ctrl_001", A_CTRL, 32'h1);
      wr("wr_lane1_only", A_CTRL, 32'h0FE, 4'b0010);
      rd("ctrl_lane0_kept", A_CTRL, 32'h1);
      wr("wr_lane0_only", A_CTRL, 32'h106, 4'b0001);
      rd("ctrl_lane0_set", A_CTRL, 32'h6);

      // reset during an outstanding strobe
      wr("wr_thr1", A_CTRL, 32'h3, 4'hF);
      pulse(31);
      @(negedge clk);
      check("irq_pre_rst", 32'(irq), 32'h1);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'(A_STAT);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ack", 32'(ack), 32'h0);
      check("midrst_dat", dat_o, 32'h0);
      check("midrst_irq", 32'(irq), 32'h0);
      repeat (2) @(negedge clk);
      check("midrst_ack_hold", 32'(ack), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", 32'(ack), 32'h0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check("post_rst_noack", 32'(ack), 32'h0);
      rd("stat_post_rst", A_STAT, 32'h10);
      rd("ctrl_post_rst", A_CTRL, 32'h0);

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(exp_dat_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
